// File: rtl/note_player_if.sv
// Command channel from the melody sequencer to the note player.
// The sequencer side drives a {half-period, duration} command under valid/ready.
interface note_player_if #(
  parameter int HALF_W = 16,
  parameter int DUR_W  = 12
);
  logic              i_valid;
  logic              o_ready;
  logic [HALF_W-1:0] i_half;
  logic [DUR_W-1:0]  i_dur;

  modport master (
    output i_valid,
    output i_half,
    output i_dur,
    input  o_ready
  );

  modport slave (
    input  i_valid,
    input  i_half,
    input  i_dur,
    output o_ready
  );
endinterface

// File: rtl/note_player.sv
// Plays {half-period, duration} commands as 50% square waves or rests for an
// exact number of duration ticks, then pulses o_done once per command.
module note_player #(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int HALF_W    = 16,
  parameter int DUR_W     = 12
) (
  input  logic         clk,
  input  logic         rst,
  note_player_if.slave cmd,
  output logic         out,
  output logic         o_busy,
  output logic         o_done
);

  localparam int TICK_CNT = CLK_FREQ / TICK_FREQ;
  localparam int PW       = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_CNT - 1);
  localparam logic [PW-1:0]     PRESC_ZERO = {PW{1'b0}};
  localparam logic [HALF_W-1:0] HALF_ZERO = {HALF_W{1'b0}};
  localparam logic [HALF_W-1:0] HALF_ONE  = {{(HALF_W-1){1'b0}}, 1'b1};
  localparam logic [DUR_W-1:0]  DUR_ZERO  = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]  DUR_ONE   = {{(DUR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [HALF_W-1:0] half_r, half_s;
  logic [HALF_W-1:0] timer_r, timer_s;
  logic [PW-1:0]     presc_r, presc_s;
  logic [DUR_W-1:0]  remaining_r, remaining_s;
  logic              out_r, out_s;
  logic              done_r, done_s;

  assign cmd.o_ready = (state_r == IDLE);
  assign o_busy      = (state_r == PLAY);
  assign out         = out_r;
  assign o_done      = done_r;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      half_r      <= HALF_ZERO;
      timer_r     <= HALF_ZERO;
      presc_r     <= PRESC_ZERO;
      remaining_r <= DUR_ZERO;
      out_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      half_r      <= half_s;
      timer_r     <= timer_s;
      presc_r     <= presc_s;
      remaining_r <= remaining_s;
      out_r       <= out_s;
      done_r      <= done_s;
    end
  end

  // Next-state, wave timer, duration prescaler and done pulse
  always_comb begin
    state_s     = state_r;
    half_s      = half_r;
    timer_s     = timer_r;
    presc_s     = presc_r;
    remaining_s = remaining_r;
    out_s       = out_r;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        out_s = 1'b0;
        if (cmd.i_valid) begin
          if (cmd.i_dur != DUR_ZERO) begin
            half_s      = cmd.i_half;
            // A rest never consults the timer, so keep it at 0 instead of wrapping.
            timer_s     = (cmd.i_half == HALF_ZERO) ? HALF_ZERO : (cmd.i_half - HALF_ONE);
            presc_s     = PRESC_MAX;
            remaining_s = cmd.i_dur;
            state_s     = PLAY;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          done_s = 1'b0;
        end
      end

      PLAY: begin
        if (half_r == HALF_ZERO) begin
          out_s = 1'b0;
        end else if (timer_r == HALF_ZERO) begin
          timer_s = half_r - HALF_ONE;
          out_s   = ~out_r;
        end else begin
          timer_s = timer_r - HALF_ONE;
        end

        // The end-of-note branch comes last so it overrides a same-edge toggle.
        if (presc_r == PRESC_ZERO) begin
          presc_s     = PRESC_MAX;
          remaining_s = remaining_r - DUR_ONE;
          if (remaining_r == DUR_ONE) begin
            state_s = IDLE;
            out_s   = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = PLAY;
          end
        end else begin
          presc_s = presc_r - {{(PW-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_s = IDLE;
        out_s   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_note_player.sv
// Randomized self-checking bench for note_player against a cycle-count model
// of the note waveform, busy/ready window and done pulse.
module tb_note_player;

  localparam int CLK_FREQ  = 1000;
  localparam int TICK_FREQ = 100;
  localparam int TICK_CNT  = CLK_FREQ / TICK_FREQ;
  localparam int HALF_W    = 16;
  localparam int DUR_W     = 12;

  logic clk;
  logic rst;
  logic out;
  logic o_busy;
  logic o_done;

  int n_pass;
  int n_total;

  note_player_if #(.HALF_W(HALF_W), .DUR_W(DUR_W)) cmd ();

  note_player #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_FREQ(TICK_FREQ),
    .HALF_W   (HALF_W),
    .DUR_W    (DUR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd),
    .out   (out),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out, busy, ready, done} m edges after the accept edge of a note.
  function automatic logic [3:0] model(input int m, input int h, input int d);
    if (m >= d * TICK_CNT) return 4'b0011;
    else if (h == 0) return 4'b0100;
    else return {(((m / h) % 2) == 1), 3'b100};
  endfunction

  // Plays one note whose command is already on the bus; optionally queues the next.
  task automatic test_note(input int h, input int d, input bit chain, input int nh, input int nd);
    int dt;
    logic [3:0] act;
    logic [3:0] exp;
    dt = d * TICK_CNT;
    n_total++;
    if (cmd.o_ready !== 1'b1) $display("FAIL accept_ready got %b expected 1", cmd.o_ready);
    else n_pass++;
    @(posedge clk);
    for (int m = 0; m <= dt; m++) begin
      @(negedge clk);
      act = {out, o_busy, cmd.o_ready, o_done};
      exp = model(m, h, d);
      n_total++;
      if (act !== exp)
        $display("FAIL note h=%0d d=%0d m=%0d out/busy/ready/done got %b expected %b", h, d, m, act, exp);
      else n_pass++;
      if (m == dt - 1) begin
        cmd.i_valid = chain;
        cmd.i_half  = HALF_W'(nh);
        cmd.i_dur   = DUR_W'(nd);
      end else if (m < dt - 1) begin
        // Bus noise while playing must be ignored.
        cmd.i_valid = 1'($urandom_range(0, 1));
        cmd.i_half  = HALF_W'($urandom);
        cmd.i_dur   = DUR_W'($urandom_range(1, 4095));
      end else begin
        cmd.i_valid = cmd.i_valid;
      end
    end
    if (!chain) begin
      @(negedge clk);
      act = {out, o_busy, cmd.o_ready, o_done};
      n_total++;
      if (act !== 4'b0010) $display("FAIL post_note h=%0d d=%0d got %b expected 0010", h, d, act);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] act;
    rst = 1'b1;
    cmd.i_valid = 1'b0;
    cmd.i_half  = '0;
    cmd.i_dur   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    act = {out, o_busy, cmd.o_ready, o_done};
    n_total++;
    if (act !== 4'b0010) $display("FAIL reset_state got %b expected 0010", act);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    cmd.i_valid = 1'b1; cmd.i_half = 16'd3; cmd.i_dur = 12'd2;
    test_note(3, 2, 1'b0, 0, 0);
  endtask

  task automatic test_rest();
    @(negedge clk);
    cmd.i_valid = 1'b1; cmd.i_half = 16'd0; cmd.i_dur = 12'd1;
    test_note(0, 1, 1'b0, 0, 0);
  endtask

  task automatic test_noop();
    logic [3:0] act;
    @(negedge clk);
    cmd.i_valid = 1'b1; cmd.i_half = 16'd1; cmd.i_dur = 12'd0;
    @(negedge clk);
    cmd.i_valid = 1'b0;
    act = {out, o_busy, cmd.o_ready, o_done};
    n_total++;
    if (act !== 4'b0011) $display("FAIL noop_done got %b expected 0011", act);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      act = {out, o_busy, cmd.o_ready, o_done};
      n_total++;
      if (act !== 4'b0010) $display("FAIL noop_after i=%0d got %b expected 0010", i, act);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd.i_valid = 1'b1; cmd.i_half = 16'd4; cmd.i_dur = 12'd2;
    test_note(4, 2, 1'b1, 2, 1);
    test_note(2, 1, 1'b0, 0, 0);
  endtask

  task automatic test_mid_reset();
    logic [3:0] act;
    logic [3:0] exp;
    @(negedge clk);
    cmd.i_valid = 1'b1; cmd.i_half = 16'd2; cmd.i_dur = 12'd3;
    @(posedge clk);
    for (int m = 0; m <= 6; m++) begin
      @(negedge clk);
      cmd.i_valid = 1'b0;
      act = {out, o_busy, cmd.o_ready, o_done};
      exp = model(m, 2, 3);
      n_total++;
      if (act !== exp) $display("FAIL pre_reset m=%0d got %b expected %b", m, act, exp);
      else n_pass++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    act = {out, o_busy, cmd.o_ready, o_done};
    n_total++;
    if (act !== 4'b0010) $display("FAIL mid_reset got %b expected 0010", act);
    else n_pass++;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      act = {out, o_busy, cmd.o_ready, o_done};
      n_total++;
      if (act !== 4'b0010) $display("FAIL after_reset i=%0d got %b expected 0010", i, act);
      else n_pass++;
    end
    cmd.i_valid = 1'b1; cmd.i_half = 16'd1; cmd.i_dur = 12'd1;
    test_note(1, 1, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int h;
    int d;
    int nh;
    int nd;
    bit chain;
    bit on_bus;
    on_bus = 1'b0;
    h = 0;
    d = 1;
    for (int i = 0; i < 6; i++) begin
      if (!on_bus) begin
        h = $urandom_range(0, 6);
        d = $urandom_range(1, 3);
        @(negedge clk);
        cmd.i_valid = 1'b1; cmd.i_half = HALF_W'(h); cmd.i_dur = DUR_W'(d);
      end
      chain = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      nh = $urandom_range(0, 6);
      nd = $urandom_range(1, 3);
      test_note(h, d, chain, nh, nd);
      on_bus = chain;
      h = nh;
      d = nd;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_rest();
    test_noop();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Programmable square-wave note generator: the runtime-loadable successor to the fixed-frequency tone generator. It accepts {half-period, duration} commands over a valid/ready handshake. It plays each command as a 50 % square wave (or a silent rest) for an exact number of duration ticks, then returns to idle and pulses `o_done`. It sits between a melody sequencer/ROM reader and the speaker/audio output pin.

## Interface

- `CLK_FREQ`, 48_000_000, clock frequency (Hz).
- `TICK_FREQ`, 1000, duration tick rate (Hz). `TICK_CNT = CLK_FREQ / TICK_FREQ`, which must be ≥ 2.
- `HALF_W`, 16, width of the half-period field, in clocks.
- `DUR_W`, 12, width of the duration field, in ticks.

Ports:

- `clk`  in  1  system clock, at `CLK_FREQ`.
- `rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  command valid.
- `o_ready`  out  1  command accepted when `i_valid && o_ready` at a rising edge.
- `i_half`  in  `HALF_W`  half-period in clocks; 0 = rest (silence).
- `i_dur`  in  `DUR_W`  note duration in ticks; 0 = no-op.
- `out`  out  1  square-wave output.
- `o_busy`  out  1  a note is playing.
- `o_done`  out  1  one-cycle pulse per completed command.

## Operation

- Two states: `IDLE` and `PLAY`.
  - `o_ready = (state == IDLE)`.
  - `o_busy = (state == PLAY)`.
  - Both are decoded directly from state.
- Internal registers:
  - latched `half`.
  - half-period timer, `HALF_W` bits.
  - tick prescaler, `$clog2(TICK_CNT)` bits.
  - `remaining`, `DUR_W` bits.
  - `out` and `o_done` registers.
- Reset, from any state, at the next edge:
  - state = `IDLE`, `out` = 0, `o_done` = 0.
  - all counters = 0.
  - A note in progress is abandoned with no `o_done` pulse.
- Accept in `IDLE` with `i_valid = 1` and `i_dur ≠ 0`:
  - latch `half = i_half`.
  - timer ← `i_half − 1`; prescaler ← `TICK_CNT − 1`; `remaining` ← `i_dur`.
  - `out` ← 0; state ← `PLAY`.
- Accept in `IDLE` with `i_dur = 0`:
  - state stays `IDLE`; `out` stays 0.
  - `o_done` ← 1 for one cycle.
- In `PLAY`, half-period timer:
  - if `half = 0`: `out` is held 0 and the timer is unused.
  - else if timer = 0: timer ← `half − 1` and `out` ← `~out`.
  - else: timer ← timer − 1.
- In `PLAY`, prescaler:
  - if prescaler = 0: prescaler ← `TICK_CNT − 1` and `remaining` ← `remaining − 1`.
  - else: prescaler ← prescaler − 1.
- End of note: at an edge with prescaler = 0 and `remaining = 1`:
  - state ← `IDLE`, `out` ← 0, `o_done` ← 1.
  - End-of-note takes priority over a simultaneous toggle.
- `o_done` is cleared on every edge where it is not set.
- Inputs are ignored while in `PLAY`; `i_half` and `i_dur` changes mid-note have no effect.
- Arithmetic: all counters are unsigned. No counter wraps; each reloads at 0.

## Timing

- Reset values: `out` = 0, `o_done` = 0, `o_ready` = 1, `o_busy` = 0.
- Let accept occur at edge k, with `half` ≥ 1.
  - First rising edge of `out` is at edge k + `half`.
  - `out` then toggles every `half` clocks; full period = 2·`half` clocks.
  - Output frequency = `CLK_FREQ / (2·half)`.
- `half = 1`: `out` toggles every clock.
- `PLAY` lasts exactly `dur·TICK_CNT` clocks.
  - State returns to `IDLE` at edge k + `dur·TICK_CNT`.
  - `o_done` is high for the following cycle only.
- Back-to-back commands:
  - The next accept can occur at edge k + `dur·TICK_CNT` + 1 (one idle cycle between notes).
  - `o_done` and `o_ready` are both high in that cycle.
- `dur = 0` command: `o_done` is high during the cycle after edge k; `o_ready` never drops.
- Each accepted command produces exactly one `o_done` pulse, unless reset intervenes.

## Test plan

Bench parameters: `CLK_FREQ` = 1000, `TICK_FREQ` = 100, so `TICK_CNT` = 10.

1. Assert `rst` for 2 cycles → `out` = 0, `o_ready` = 1, `o_busy` = 0, `o_done` = 0. Verify also asserting `rst` mid-note (see 6).
2. Accept `half` = 3, `dur` = 2 at edge k → `out` toggles at k+3, 6, 9, 12, 15, 18 (1,0,1,0,1,0). `o_busy` is high from k+1 through k+20. At k+20: `IDLE`, `out` = 0, `o_done` = 1 for exactly one cycle.
3. Accept `half` = 0 (rest), `dur` = 1 → `out` stays 0 for 10 cycles. `o_busy` = 1 for 10 cycles, then one `o_done` pulse.
4. Accept `half` = 1, `dur` = 0 → no `PLAY`. `o_ready` stays 1, `out` stays 0, `o_done` = 1 in the next cycle only.
5. Hold `i_valid` high with two queued commands, changing `i_half` mid-note → the first command's wave is unaffected. The second command is accepted at the first `o_ready` cycle after the end, i.e. one idle cycle between notes.
6. Accept `half` = 2, `dur` = 3, then assert `rst` at k+7 → after that edge: `out` = 0, `o_ready` = 1, and no `o_done` pulse. A new command is accepted normally after `rst` deasserts.
